// File: rtl/fifo_flags.sv
// fifo_flags
// Synchronous show-ahead FIFO with registered occupancy count, registered
// status flags and sticky overflow/underflow error flags.
//
// Ports
//   clock        : single system clock, all state updates on its rising edge
//   reset        : synchronous active-high reset to empty, errors cleared
//   din          : write data
//   write        : write strobe
//   read         : read strobe, consumes the word currently on dout
//   flush        : synchronous discard of all stored words
//   clr_err      : synchronous clear of overflow and underflow
//   dout         : oldest stored word, combinational from storage
//   full         : count == DEPTH
//   empty        : count == 0
//   almost_full  : count >= AFULL_LEVEL
//   almost_empty : count <= AEMPTY_LEVEL
//   count        : number of stored words, 0..DEPTH
//   overflow     : sticky, write attempted while full without a read
//   underflow    : sticky, read attempted while empty
module fifo_flags #(
  parameter int LOG2_DEPTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int AFULL_LEVEL  = 2**LOG2_DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write,
  input  logic                  read,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;
  localparam logic [LOG2_DEPTH-1:0] PtrOne = 1;

  // Reset values of the threshold flags. For sensible levels both are 0, so
  // together with the inverted empty encoding below every state register
  // resets to all-zeros and a zero power-up state equals the reset state.
  localparam logic AFullRst     = (AFULL_LEVEL <= 0);
  localparam logic NotAEmptyRst = (AEMPTY_LEVEL < 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LOG2_DEPTH-1:0] wrPtr_q, wrPtr_d;
  logic [LOG2_DEPTH-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  notEmpty_q, notEmpty_d;
  logic                  aFull_q, aFull_d;
  logic                  notAEmpty_q, notAEmpty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wrAccept;
  logic rdAccept;
  logic memWrite;

  // Strobe qualification. A write into a full FIFO is still accepted when a
  // read on the same edge frees a slot; a read of an empty FIFO never is.
  // Flush and reset override both strobes and suppress error detection.
  always_comb begin
    wrAccept = write & (~full_q | read) & ~flush;
    rdAccept = read & notEmpty_q & ~flush;
    memWrite = wrAccept & ~reset;
  end

  // Next-state for pointers, count, flags and sticky errors. Flags are
  // computed from the next count so they line up with the registered count.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) wrPtr_d = wrPtr_q + PtrOne;
      if (rdAccept) rdPtr_d = rdPtr_q + PtrOne;
      count_d = count_q + CW'(wrAccept) - CW'(rdAccept);
      if (write & full_q & ~read) overflow_d  = 1'b1;
      if (read & ~notEmpty_q)     underflow_d = 1'b1;
    end

    full_d      = (count_d == CW'(DEPTH));
    notEmpty_d  = (count_d != '0);
    aFull_d     = (int'(count_d) >= AFULL_LEVEL);
    notAEmpty_d = !(int'(count_d) <= AEMPTY_LEVEL);
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      notEmpty_q  <= 1'b0;
      aFull_q     <= AFullRst;
      notAEmpty_q <= NotAEmptyRst;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      notEmpty_q  <= notEmpty_d;
      aFull_q     <= aFull_d;
      notAEmpty_q <= notAEmpty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (memWrite) mem[wrPtr_q] <= din;
  end

  always_comb begin
    dout         = mem[rdPtr_q];
    full         = full_q;
    empty        = ~notEmpty_q;
    almost_full  = aFull_q;
    almost_empty = ~notAEmpty_q;
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags
// Self-checking bench for fifo_flags (default parameters). A queue-based
// reference model tracks the stored words and error flags; every cycle the
// DUT count, flags, errors and (when non-empty) dout are compared to it.
module tb_fifo_flags;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = '0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int testsRun = 0;
  int failures = 0;

  logic [7:0] modelQ[$];
  bit         modelOvf = 1'b0;
  bit         modelUnf = 1'b0;

  fifo_flags #(
    .LOG2_DEPTH(4),
    .DATA_WIDTH(8),
    .AFULL_LEVEL(14),
    .AEMPTY_LEVEL(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .din(din),
    .write(write),
    .read(read),
    .flush(flush),
    .clr_err(clr_err),
    .dout(dout),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Compare every observable output against the reference model.
  task automatic checkAll(input string ctx);
    int n;
    n = modelQ.size();
    checkOutput({ctx, ".count"}, 32'(count), 32'(n));
    checkOutput({ctx, ".full"}, 32'(full), 32'(n == DEPTH));
    checkOutput({ctx, ".empty"}, 32'(empty), 32'(n == 0));
    checkOutput({ctx, ".almost_full"}, 32'(almost_full), 32'(n >= 14));
    checkOutput({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    checkOutput({ctx, ".overflow"}, 32'(overflow), 32'(modelOvf));
    checkOutput({ctx, ".underflow"}, 32'(underflow), 32'(modelUnf));
    if (n > 0) checkOutput({ctx, ".dout"}, 32'(dout), 32'(modelQ[0]));
  endtask

  // Drive one cycle of inputs, advance the reference model on the rising
  // edge, then check the outputs shortly after the edge.
  task automatic applyStimulus(input string ctx, input bit w, input bit r,
                               input bit f, input bit c, input bit rs,
                               input logic [7:0] d);
    bit wasFull, wasEmpty;
    @(negedge clock);
    write = w; read = r; flush = f; clr_err = c; reset = rs; din = d;
    @(posedge clock);
    wasFull  = (modelQ.size() == DEPTH);
    wasEmpty = (modelQ.size() == 0);
    if (rs) begin
      modelQ.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
    end else if (f) begin
      modelQ.delete();
      if (c) begin modelOvf = 1'b0; modelUnf = 1'b0; end
    end else begin
      if (c) begin modelOvf = 1'b0; modelUnf = 1'b0; end
      if (w && wasFull && !r) modelOvf = 1'b1;
      if (r && wasEmpty) modelUnf = 1'b1;
      if (r && !wasEmpty) void'(modelQ.pop_front());
      if (w && (!wasFull || r)) modelQ.push_back(d);
    end
    #1;
    checkAll(ctx);
  endtask

  initial begin
    bit w, r, f, c, rs;
    int wProb, rProb;

    applyStimulus("reset", 0, 0, 0, 0, 1, 8'h00);

    // Fill with 0x11..0x20, then one write too many.
    for (int i = 0; i < 16; i++) applyStimulus("fill", 1, 0, 0, 0, 0, 8'(8'h11 + i));
    applyStimulus("overflowWrite", 1, 0, 0, 0, 0, 8'hEE);

    // Drain in order, then one read too many.
    for (int i = 0; i < 16; i++) applyStimulus("drain", 0, 1, 0, 0, 0, 8'h00);
    applyStimulus("underflowRead", 0, 1, 0, 0, 0, 8'h00);
    applyStimulus("clrErr", 0, 0, 0, 1, 0, 8'h00);

    // Read+write while full.
    for (int i = 0; i < 16; i++) applyStimulus("refill", 1, 0, 0, 0, 0, 8'(8'h30 + i));
    applyStimulus("rwFull", 1, 1, 0, 0, 0, 8'hAA);
    for (int i = 0; i < 16; i++) applyStimulus("drainRw", 0, 1, 0, 0, 0, 8'h00);

    // Read+write while empty, then clear the error.
    applyStimulus("rwEmpty", 1, 1, 0, 0, 0, 8'h55);
    applyStimulus("clrUnf", 0, 0, 0, 1, 0, 8'h00);

    // Move pointers to 14, hold 5 words across the wrap, flush with write.
    applyStimulus("reset2", 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 14; i++) applyStimulus("advance", 1, 1, 0, 0, 0, 8'(i));
    applyStimulus("advanceDrain", 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus("wrap", 1, 0, 0, 0, 0, 8'(8'h60 + i));
    applyStimulus("flushWrite", 1, 0, 1, 0, 0, 8'hFF);
    for (int i = 0; i < 3; i++) applyStimulus("postFlush", 1, 0, 0, 0, 0, 8'(8'h70 + i));
    for (int i = 0; i < 3; i++) applyStimulus("postFlushRd", 0, 1, 0, 0, 0, 8'h00);

    // Reset mid-operation with a write pending and an error flag set.
    applyStimulus("setUnf", 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) applyStimulus("nine", 1, 0, 0, 0, 0, 8'(8'h80 + i));
    applyStimulus("resetWrite", 1, 0, 0, 0, 1, 8'h99);

    // Randomized phases with varying write/read bias.
    for (int phase = 0; phase < 8; phase++) begin
      wProb = (phase % 4) * 30 + 5;
      rProb = 95 - wProb;
      for (int i = 0; i < 250; i++) begin
        w  = ($urandom_range(99) < wProb);
        r  = ($urandom_range(99) < rProb);
        f  = ($urandom_range(59) == 0);
        c  = ($urandom_range(24) == 0);
        rs = ($urandom_range(299) == 0);
        applyStimulus("random", w, r, f, c, rs, 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
